// File: rtl/line_drawer_stream_pkg.sv
// Shared types for the Bresenham line rasteriser: FSM state encoding.
package line_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2,
    FIN  = 2'd3
  } line_state_e;

endpackage

// File: rtl/line_drawer_stream_if.sv
// Command and pixel-stream bundle between a line requester/frame-buffer writer and the rasteriser.
interface line_drawer_stream_if #(
   parameter int COORD_W = 11
);
   // Pixel stream: a pixel moves when pix_valid && pix_ready at a rising clk edge; while
   // pix_valid is high and pix_ready low, pix_x/pix_y hold and pix_valid stays high.
   logic                      start;
   logic signed [COORD_W-1:0] x0;
   logic signed [COORD_W-1:0] y0;
   logic signed [COORD_W-1:0] x1;
   logic signed [COORD_W-1:0] y1;
   logic                      busy;
   logic signed [COORD_W-1:0] pix_x;
   logic signed [COORD_W-1:0] pix_y;
   logic                      pix_valid;
   logic                      pix_ready;
   logic                      done;

   modport master (
      input  start, x0, y0, x1, y1, pix_ready,
      output busy, pix_x, pix_y, pix_valid, done
   );

   modport slave (
      output start, x0, y0, x1, y1, pix_ready,
      input  busy, pix_x, pix_y, pix_valid, done
   );
endinterface

// File: rtl/line_drawer_stream_step_timer.sv
// Loadable down-counter with a zero flag; paces the gap between successive pixels.
module step_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);
endmodule

// File: rtl/line_drawer_stream.sv
// Bresenham line rasteriser: captures endpoints on start and streams every pixel of the line.
module line_drawer_stream
   import line_pkg::*;
#(
   parameter int COORD_W  = 11,
   parameter int STEP_DIV = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   line_drawer_stream_if.master bus,
   output logic [1:0]           dbg_state
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_EMIT = EMIT;
   localparam logic [1:0] S_WAIT = WAIT;
   localparam logic [1:0] S_FIN  = FIN;

   localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV + 1) : 1;
   localparam logic [TW-1:0] LOAD_V = TW'((STEP_DIV > 1) ? (STEP_DIV - 2) : 0);
   localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1);

   logic [1:0]                state;
   logic signed [COORD_W-1:0] x, y, x1_r, y1_r;
   logic signed [COORD_W+1:0] dx, dy, err;
   logic                      sx_neg, sy_neg;

   logic signed [COORD_W+1:0] x0e, y0e, x1e, y1e, dx_n, dy_n, err_next;
   logic signed [COORD_W+2:0] e2, dx_w, dy_w;
   logic                      step_x, step_y, at_end, hs;
   logic                      tmr_load, tmr_dec, tmr_zero;

   assign x0e = {{2{bus.x0[COORD_W-1]}}, bus.x0};
   assign y0e = {{2{bus.y0[COORD_W-1]}}, bus.y0};
   assign x1e = {{2{bus.x1[COORD_W-1]}}, bus.x1};
   assign y1e = {{2{bus.y1[COORD_W-1]}}, bus.y1};

   // dx is |x1-x0|, dy is -|y1-y0|, so the error term starts at their sum.
   assign dx_n = (x1e >= x0e) ? (x1e - x0e) : (x0e - x1e);
   assign dy_n = (y1e >= y0e) ? (y0e - y1e) : (y1e - y0e);

   assign e2   = $signed({err, 1'b0});
   assign dx_w = {dx[COORD_W+1], dx};
   assign dy_w = {dy[COORD_W+1], dy};

   assign step_x   = (e2 >= dy_w);
   assign step_y   = (e2 <= dx_w);
   assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
   assign at_end   = (x == x1_r) && (y == y1_r);
   assign hs       = (state == S_EMIT) && bus.pix_ready;

   assign tmr_load = hs && !at_end;
   assign tmr_dec  = (state == S_WAIT);

   generate
      if (STEP_DIV > 1) begin : g_timer
         step_timer #(.W(TW)) u_timer (
            .clk      (clk),
            .reset    (reset),
            .load     (tmr_load),
            .dec      (tmr_dec),
            .load_val (LOAD_V),
            .zero     (tmr_zero)
         );
      end else begin : g_no_timer
         logic unused_tmr;
         assign unused_tmr = ^{tmr_load, tmr_dec, LOAD_V};
         assign tmr_zero   = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         x      <= '0;
         y      <= '0;
         x1_r   <= '0;
         y1_r   <= '0;
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         sx_neg <= 1'b0;
         sy_neg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  x      <= bus.x0;
                  y      <= bus.y0;
                  x1_r   <= bus.x1;
                  y1_r   <= bus.y1;
                  dx     <= dx_n;
                  dy     <= dy_n;
                  err    <= dx_n + dy_n;
                  sx_neg <= !(bus.x0 < bus.x1);
                  sy_neg <= !(bus.y0 < bus.y1);
                  state  <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (hs) begin
                  if (at_end) begin
                     state <= S_FIN;
                  end else begin
                     if (step_x) x <= sx_neg ? (x - ONE) : (x + ONE);
                     if (step_y) y <= sy_neg ? (y - ONE) : (y + ONE);
                     err   <= err_next;
                     state <= (STEP_DIV > 1) ? S_WAIT : S_EMIT;
                  end
               end
            end
            S_WAIT: begin
               if (tmr_zero) state <= S_EMIT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.pix_valid = (state == S_EMIT);
   assign bus.done      = (state == S_FIN);
   assign bus.busy      = (state != S_IDLE);
   assign bus.pix_x     = x;
   assign bus.pix_y     = y;
   assign dbg_state     = state;
endmodule
